sys_bus_arb: RTL and testbench
==============================

// Module: sys_bus_arb
// PURPOSE
//  Two-master round-robin arbiter and sequencer for the SoC memory-mapped bus.
//  Sits between the masters and the address decoder / read-data mux, which stay unchanged.
//   - M0 = CPU load/store port; M1 = DMA/host port.
//  Sequences one transfer at a time: grant, issue address/write, wait read latency,
//  capture read data, ack the owner.
// PARAMETERS
//  ADDR_W  10  word-address width (byte address bits [11:2])
//  DATA_W  32  data width
//  RD_LAT  1   cycles from ISSUE until bus_rd is valid; legal range 1..7
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous reset, active-low (0 = reset)
//  m0_req     in   1       M0 transfer request; held until m0_ack
//  m0_we      in   1       M0 write (1) / read (0)
//  m0_a       in   ADDR_W  M0 word address
//  m0_wd      in   DATA_W  M0 write data
//  m0_ack     out  1       one-cycle completion pulse to M0
//  m1_req, m1_we, m1_a, m1_wd, m1_ack   same as the M0 ports, for M1
//  m_rd       out  DATA_W  captured read data; valid while any ack is high
//  bus_we     out  1       write enable to the decoder
//  bus_a      out  ADDR_W  address to the decoder
//  bus_wd     out  DATA_W  write data to the bus
//  bus_rd     in   DATA_W  read data from the decoder read mux
//  busy       out  1       high in every state except IDLE
//  owner      out  1       current/last granted master (0 = M0, 1 = M1)
// BEHAVIOUR
//  Reset (rst == 0 at a clock edge):
//   - state = IDLE; all outputs 0; pointer prio = 0 (M0 favoured); wait counter = 0.
//   - Applies mid-transfer: abort, no ack; bus_we is 0 from the next cycle.
//  All outputs are registered.
//  FSM states: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
//   IDLE:
//    - No req: stay in IDLE.
//    - One req: grant that master.
//    - Both req: grant master `prio`, then prio <= ~granted.
//    - On grant: latch the owner's we/a/wd and go to ISSUE.
//   ISSUE (exactly 1 cycle):
//    - bus_a = latched address; bus_wd = latched write data.
//    - bus_we = latched we, high in this cycle only.
//   WAIT:
//    - bus_a and bus_wd held; bus_we = 0.
//    - Counter runs 1..RD_LAT.
//    - At the edge ending wait cycle RD_LAT: m_rd <= bus_rd, go to ACK.
//   ACK (exactly 1 cycle):
//    - Owner's ack = 1; m_rd valid.
//    - Requests are ignored (the owner's req is still high); then go to IDLE.
//    - Bus outputs return to 0.
//  Timing: req sampled in IDLE at cycle 0 -> ISSUE in cycle 1 -> ack in cycle 2+RD_LAT.
//   - Writes have the same timing; m_rd is don't-care for writes.
//  Back-to-back: minimum spacing between a master's transfers is 3+RD_LAT cycles.
//  Fairness:
//   - With both reqs held continuously, grants strictly alternate.
//   - prio updates only on a contested grant.
//  Outside ISSUE/WAIT: bus_a = 0, bus_wd = 0, bus_we = 0.
//  Protocol rules:
//   - Master inputs are sampled only in IDLE at grant.
//   - A req dropped before its ack does not cancel the transfer; the ack is still pulsed.
//   - m0_ack and m1_ack are never high together.
//  RD_LAT outside 1..7 is a configuration error; the implementation clamps it to 1.
// TESTING
//  T1 reset: rst=0 for 2 cycles with both reqs high
//     -> all outputs 0, busy=0; first contested grant goes to M0.
//  T2 single read, RD_LAT=1: M0 reads a=0x000, bus_rd=0xDEADBEEF
//     -> bus_a=0x000 in cycles 1-2, bus_we never high, m0_ack in cycle 3 with m_rd=0xDEADBEEF.
//  T3 single write: M1 writes a=0x200, wd=0x5
//     -> bus_we=1 only in cycle 1 with bus_a=0x200, bus_wd=0x5; m1_ack in cycle 3; m0_ack stays 0.
//  T4 contention: both reqs held for 4 transfers
//     -> owner sequence 0,1,0,1; acks 4 cycles apart; never simultaneous.
//  T5 RD_LAT=3: M1 reads a=0x240 (bus_rd changes to 0x7 in cycle 4)
//     -> m1_ack in cycle 5 with m_rd=0x7; bus_a stable through cycles 1-4.
//  T6 reset mid-WAIT during an M0 write
//     -> no ack, bus_we=0 next cycle, IDLE; the next transfer completes normally.

Source files
------------

// File: rtl/sys_bus_arb_if.sv
// Bus bundle between the two masters, the arbiter and the decoder/read mux.
// The arbiter uses the slave modport; the master modport is the mirror view.
interface sys_bus_arb_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_a;
  logic [DATA_W-1:0] m0_wd;
  logic              m0_ack;
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_a;
  logic [DATA_W-1:0] m1_wd;
  logic              m1_ack;
  logic [DATA_W-1:0] m_rd;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_a;
  logic [DATA_W-1:0] bus_wd;
  logic [DATA_W-1:0] bus_rd;
  logic              busy;
  logic              owner;

  modport slave (
    input  m0_req, m0_we, m0_a, m0_wd,
    input  m1_req, m1_we, m1_a, m1_wd,
    input  bus_rd,
    output m0_ack, m1_ack, m_rd,
    output bus_we, bus_a, bus_wd,
    output busy, owner
  );

  modport master (
    output m0_req, m0_we, m0_a, m0_wd,
    output m1_req, m1_we, m1_a, m1_wd,
    output bus_rd,
    input  m0_ack, m1_ack, m_rd,
    input  bus_we, bus_a, bus_wd,
    input  busy, owner
  );
endinterface

// File: rtl/sys_bus_arb.sv
// Two-master round-robin arbiter and transfer sequencer.
// One transfer at a time: grant in IDLE, drive the bus for one ISSUE cycle,
// wait RD_LAT cycles for read data, then pulse the owner's ack for one cycle.
// Every output comes straight from a flop.
module sys_bus_arb #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sys_bus_arb_if.slave  arb_if
);

  // Out-of-range read latencies fall back to a single wait cycle.
  localparam int          LAT   = (RD_LAT < 1 || RD_LAT > 7) ? 1 : RD_LAT;
  localparam logic [2:0]  LAT_C = 3'(LAT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t            state_q;
  logic              prio_q;
  logic [2:0]        cnt_q;
  logic              owner_q;
  logic              busy_q;
  logic              m0_ack_q;
  logic              m1_ack_q;
  logic [DATA_W-1:0] m_rd_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_a_q;
  logic [DATA_W-1:0] bus_wd_q;

  logic gnt_vld_d;
  logic gnt_sel_d;
  logic contested_d;

  // Pick the master to grant: a lone requester wins, a tie goes to prio.
  always_comb begin
    gnt_vld_d   = arb_if.m0_req | arb_if.m1_req;
    contested_d = arb_if.m0_req & arb_if.m1_req;
    gnt_sel_d   = 1'b0;
    if (contested_d) begin
      gnt_sel_d = prio_q;
    end else if (arb_if.m1_req) begin
      gnt_sel_d = 1'b1;
    end
  end

  // Sequencer FSM; the latched bus address/data double as the transfer latch.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      cnt_q    <= 3'd0;
      owner_q  <= 1'b0;
      busy_q   <= 1'b0;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m_rd_q   <= '0;
      bus_we_q <= 1'b0;
      bus_a_q  <= '0;
      bus_wd_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld_d) begin
            state_q  <= ST_ISSUE;
            owner_q  <= gnt_sel_d;
            busy_q   <= 1'b1;
            if (contested_d) begin
              prio_q <= ~gnt_sel_d;
            end
            bus_we_q <= gnt_sel_d ? arb_if.m1_we : arb_if.m0_we;
            bus_a_q  <= gnt_sel_d ? arb_if.m1_a  : arb_if.m0_a;
            bus_wd_q <= gnt_sel_d ? arb_if.m1_wd : arb_if.m0_wd;
          end
        end
        ST_ISSUE: begin
          bus_we_q <= 1'b0;
          cnt_q    <= 3'd1;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == LAT_C) begin
            m_rd_q   <= arb_if.bus_rd;
            m0_ack_q <= ~owner_q;
            m1_ack_q <= owner_q;
            bus_a_q  <= '0;
            bus_wd_q <= '0;
            cnt_q    <= 3'd0;
            state_q  <= ST_ACK;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_ACK: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign arb_if.m0_ack = m0_ack_q;
  assign arb_if.m1_ack = m1_ack_q;
  assign arb_if.m_rd   = m_rd_q;
  assign arb_if.bus_we = bus_we_q;
  assign arb_if.bus_a  = bus_a_q;
  assign arb_if.bus_wd = bus_wd_q;
  assign arb_if.busy   = busy_q;
  assign arb_if.owner  = owner_q;

endmodule

// File: tb/tb_sys_bus_arb.sv
// Directed bench for sys_bus_arb: one instance at RD_LAT=1 (ifA) and one at
// RD_LAT=3 (ifB). Inputs change and outputs are sampled 2ns after each edge.
module tb_sys_bus_arb;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sys_bus_arb_if #(.ADDR_W(10), .DATA_W(32)) ifA ();
  sys_bus_arb_if #(.ADDR_W(10), .DATA_W(32)) ifB ();

  sys_bus_arb #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) dutA (
    .clk_i  (clk),
    .rst_i  (rst),
    .arb_if (ifA)
  );

  sys_bus_arb #(.ADDR_W(10), .DATA_W(32), .RD_LAT(3)) dutB (
    .clk_i  (clk),
    .rst_i  (rst),
    .arb_if (ifB)
  );

  // Free-running 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one master of the RD_LAT=1 instance.
  task automatic applyStimulus(input bit m, input logic req, input logic we,
                               input logic [9:0] a, input logic [31:0] wd);
    if (m) begin
      ifA.m1_req = req; ifA.m1_we = we; ifA.m1_a = a; ifA.m1_wd = wd;
    end else begin
      ifA.m0_req = req; ifA.m0_we = we; ifA.m0_a = a; ifA.m0_wd = wd;
    end
  endtask

  // Linear sequence of directed steps.
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, 32'h0);
    ifA.bus_rd = 32'h0;
    ifB.m0_req = 1'b0; ifB.m0_we = 1'b0; ifB.m0_a = '0; ifB.m0_wd = '0;
    ifB.m1_req = 1'b0; ifB.m1_we = 1'b0; ifB.m1_a = '0; ifB.m1_wd = '0;
    ifB.bus_rd = 32'h0;

    $display("[TB] T1 reset with both requests high");
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h011, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h022, 32'h0);
    tick();
    tick();
    checkOutput("t1_m0_ack", 32'(ifA.m0_ack), 32'h0);
    checkOutput("t1_m1_ack", 32'(ifA.m1_ack), 32'h0);
    checkOutput("t1_m_rd",   ifA.m_rd,        32'h0);
    checkOutput("t1_bus_we", 32'(ifA.bus_we), 32'h0);
    checkOutput("t1_bus_a",  32'(ifA.bus_a),  32'h0);
    checkOutput("t1_bus_wd", ifA.bus_wd,      32'h0);
    checkOutput("t1_busy",   32'(ifA.busy),   32'h0);
    checkOutput("t1_owner",  32'(ifA.owner),  32'h0);
    rst = 1'b1;
    tick();
    checkOutput("t1_grant_owner", 32'(ifA.owner), 32'h0);
    checkOutput("t1_grant_addr",  32'(ifA.bus_a), 32'h011);
    checkOutput("t1_grant_busy",  32'(ifA.busy),  32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, 32'h0);
    tick();
    tick();
    checkOutput("t1_dropped_req_ack", 32'(ifA.m0_ack), 32'h1);
    checkOutput("t1_other_ack",       32'(ifA.m1_ack), 32'h0);
    tick();
    checkOutput("t1_idle_busy", 32'(ifA.busy), 32'h0);

    $display("[TB] T2 single read by M0");
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000, 32'h1234);
    ifA.bus_rd = 32'hDEADBEEF;
    tick();
    checkOutput("t2_c1_bus_a",  32'(ifA.bus_a),  32'h0);
    checkOutput("t2_c1_bus_wd", ifA.bus_wd,      32'h1234);
    checkOutput("t2_c1_bus_we", 32'(ifA.bus_we), 32'h0);
    checkOutput("t2_c1_owner",  32'(ifA.owner),  32'h0);
    checkOutput("t2_c1_busy",   32'(ifA.busy),   32'h1);
    tick();
    checkOutput("t2_c2_bus_wd", ifA.bus_wd,      32'h1234);
    checkOutput("t2_c2_bus_we", 32'(ifA.bus_we), 32'h0);
    checkOutput("t2_c2_m0_ack", 32'(ifA.m0_ack), 32'h0);
    tick();
    checkOutput("t2_c3_m0_ack", 32'(ifA.m0_ack), 32'h1);
    checkOutput("t2_c3_m1_ack", 32'(ifA.m1_ack), 32'h0);
    checkOutput("t2_c3_m_rd",   ifA.m_rd,        32'hDEADBEEF);
    checkOutput("t2_c3_bus_wd", ifA.bus_wd,      32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
    tick();
    checkOutput("t2_c4_m0_ack", 32'(ifA.m0_ack), 32'h0);
    checkOutput("t2_c4_busy",   32'(ifA.busy),   32'h0);

    $display("[TB] T3 single write by M1");
    applyStimulus(1'b1, 1'b1, 1'b1, 10'h200, 32'h5);
    tick();
    checkOutput("t3_c1_bus_we", 32'(ifA.bus_we), 32'h1);
    checkOutput("t3_c1_bus_a",  32'(ifA.bus_a),  32'h200);
    checkOutput("t3_c1_bus_wd", ifA.bus_wd,      32'h5);
    checkOutput("t3_c1_owner",  32'(ifA.owner),  32'h1);
    tick();
    checkOutput("t3_c2_bus_we", 32'(ifA.bus_we), 32'h0);
    checkOutput("t3_c2_bus_a",  32'(ifA.bus_a),  32'h200);
    tick();
    checkOutput("t3_c3_m1_ack", 32'(ifA.m1_ack), 32'h1);
    checkOutput("t3_c3_m0_ack", 32'(ifA.m0_ack), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, 32'h0);
    tick();
    checkOutput("t3_c4_m1_ack", 32'(ifA.m1_ack), 32'h0);
    checkOutput("t3_c4_bus_a",  32'(ifA.bus_a),  32'h0);
    checkOutput("t3_c4_bus_we", 32'(ifA.bus_we), 32'h0);

    $display("[TB] reset pulse to restore M0 priority");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("rp_busy", 32'(ifA.busy), 32'h0);

    $display("[TB] T4 contention over four transfers");
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h0A0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h0B1, 32'h0);
    for (int k = 0; k < 4; k++) begin
      ifA.bus_rd = 32'h100 + 32'(k);
      tick();
      checkOutput("t4_owner", 32'(ifA.owner), 32'(k % 2));
      checkOutput("t4_bus_a", 32'(ifA.bus_a), (k % 2 == 0) ? 32'h0A0 : 32'h0B1);
      tick();
      tick();
      checkOutput("t4_m0_ack", 32'(ifA.m0_ack), (k % 2 == 0) ? 32'h1 : 32'h0);
      checkOutput("t4_m1_ack", 32'(ifA.m1_ack), (k % 2 == 1) ? 32'h1 : 32'h0);
      checkOutput("t4_m_rd",   ifA.m_rd,        32'h100 + 32'(k));
      if (k == 3) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, 32'h0);
      end
      tick();
      checkOutput("t4_idle_acks", 32'({ifA.m0_ack, ifA.m1_ack}), 32'h0);
      checkOutput("t4_idle_busy", 32'(ifA.busy), 32'h0);
    end

    $display("[TB] T5 read with RD_LAT=3 by M1");
    ifB.m1_req = 1'b1; ifB.m1_we = 1'b0; ifB.m1_a = 10'h240;
    ifB.bus_rd = 32'h3;
    tick();
    checkOutput("t5_c1_bus_a", 32'(ifB.bus_a), 32'h240);
    checkOutput("t5_c1_owner", 32'(ifB.owner), 32'h1);
    tick();
    checkOutput("t5_c2_bus_a", 32'(ifB.bus_a), 32'h240);
    tick();
    checkOutput("t5_c3_bus_a",  32'(ifB.bus_a),  32'h240);
    checkOutput("t5_c3_m1_ack", 32'(ifB.m1_ack), 32'h0);
    ifB.bus_rd = 32'h7;
    tick();
    checkOutput("t5_c4_bus_a",  32'(ifB.bus_a),  32'h240);
    checkOutput("t5_c4_m1_ack", 32'(ifB.m1_ack), 32'h0);
    tick();
    checkOutput("t5_c5_m1_ack", 32'(ifB.m1_ack), 32'h1);
    checkOutput("t5_c5_m0_ack", 32'(ifB.m0_ack), 32'h0);
    checkOutput("t5_c5_m_rd",   ifB.m_rd,        32'h7);
    ifB.m1_req = 1'b0;
    tick();
    checkOutput("t5_c6_m1_ack", 32'(ifB.m1_ack), 32'h0);
    checkOutput("t5_c6_busy",   32'(ifB.busy),   32'h0);

    $display("[TB] T6 reset in the middle of an M0 write");
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h03C, 32'hAA);
    tick();
    checkOutput("t6_c1_bus_we", 32'(ifA.bus_we), 32'h1);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
    tick();
    rst = 1'b1;
    checkOutput("t6_rst_bus_we", 32'(ifA.bus_we), 32'h0);
    checkOutput("t6_rst_busy",   32'(ifA.busy),   32'h0);
    checkOutput("t6_rst_m0_ack", 32'(ifA.m0_ack), 32'h0);
    checkOutput("t6_rst_bus_a",  32'(ifA.bus_a),  32'h0);
    tick();
    checkOutput("t6_no_late_ack", 32'(ifA.m0_ack), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h03C, 32'h0);
    ifA.bus_rd = 32'hCAFE;
    tick();
    checkOutput("t6_next_owner", 32'(ifA.owner), 32'h0);
    checkOutput("t6_next_bus_a", 32'(ifA.bus_a), 32'h03C);
    tick();
    tick();
    checkOutput("t6_next_m0_ack", 32'(ifA.m0_ack), 32'h1);
    checkOutput("t6_next_m_rd",   ifA.m_rd,        32'hCAFE);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
    tick();
    checkOutput("t6_final_busy", 32'(ifA.busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
